// File: rtl/rv_mem_arbiter.sv
// Two-port round-robin front end for a single-port memory: p0 = instruction fetch, p1 = load/store.
// Converts byte address/size to word index, byte lanes and shifted data; formats load data on return.
module rv_mem_arbiter #(
    parameter int MEM_SIZE_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_req_we,
    input  logic [31:0] p0_req_addr,
    input  logic [1:0]  p0_req_size,
    input  logic        p0_req_unsigned,
    input  logic [31:0] p0_req_wdata,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_rdata,
    output logic        p0_rsp_err,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_req_we,
    input  logic [31:0] p1_req_addr,
    input  logic [1:0]  p1_req_size,
    input  logic        p1_req_unsigned,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_rdata,
    output logic        p1_rsp_err,

    output logic [31:0] mem_addr,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rd_data
);

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_SIZE_WORDS);

    // Realign the addressed lane to bit 0, then sign- or zero-extend by access size.
    function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] size,
                                             input logic uns, input logic [1:0] off);
        logic        [31:0] sh;
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        logic signed [31:0] ext;
        sh  = rd >> {off, 3'b000};
        b8  = sh[7:0];
        h16 = sh[15:0];
        case (size)
            2'b00:   ext = uns ? signed'({24'd0, sh[7:0]})  : 32'(b8);
            2'b01:   ext = uns ? signed'({16'd0, sh[15:0]}) : 32'(h16);
            default: ext = signed'(sh);
        endcase
        return ext;
    endfunction

    logic        prio_p1;
    logic        gnt0, gnt1, gnt;
    logic        sel_we, sel_uns;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_size, off;
    logic [3:0]  be;
    logic        misalign, illegal, out_of_range, err;

    // Request stage: arbitration and decode
    always_comb begin
        gnt0 = rst_n & p0_req_valid & (~p1_req_valid | ~prio_p1);
        gnt1 = rst_n & p1_req_valid & (~p0_req_valid | prio_p1);
        gnt  = gnt0 | gnt1;
    end

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    always_comb begin
        sel_we    = gnt1 ? p1_req_we       : p0_req_we;
        sel_addr  = gnt1 ? p1_req_addr     : p0_req_addr;
        sel_size  = gnt1 ? p1_req_size     : p0_req_size;
        sel_uns   = gnt1 ? p1_req_unsigned : p0_req_unsigned;
        sel_wdata = gnt1 ? p1_req_wdata    : p0_req_wdata;
    end

    always_comb begin
        off      = sel_addr[1:0];
        be       = 4'b0000;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (sel_size)
            2'b00: be = 4'b0001 << off;
            2'b01: begin
                be       = 4'b0011 << off;
                misalign = off[0];
            end
            2'b10: begin
                be       = 4'b1111;
                misalign = |off;
            end
            default: illegal = 1'b1;
        endcase
        out_of_range = sel_addr[31:2] >= WORD_LIMIT;
        err          = misalign | illegal | out_of_range;
    end

    assign mem_addr    = {2'b00, sel_addr[31:2]};
    assign mem_wr_data = sel_wdata << {off, 3'b000};
    assign mem_wr_en   = gnt & sel_we & ~err;
    assign mem_byte_en = (gnt & ~err) ? be : 4'b0000;

    logic        vld_p1, id_p1, we_p1, uns_p1, err_p1;
    logic [1:0]  size_p1, off_p1;

    // Response metadata register, loaded on the grant edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_p1 <= 1'b0;
            vld_p1  <= 1'b0;
            id_p1   <= 1'b0;
            we_p1   <= 1'b0;
            uns_p1  <= 1'b0;
            err_p1  <= 1'b0;
            size_p1 <= 2'b00;
            off_p1  <= 2'b00;
        end else begin
            vld_p1 <= gnt;
            if (gnt) begin
                prio_p1 <= gnt0;
                id_p1   <= gnt1;
                we_p1   <= sel_we;
                uns_p1  <= sel_uns;
                err_p1  <= err;
                size_p1 <= sel_size;
                off_p1  <= off;
            end
        end
    end

    // Response stage: format and route to the owning requester
    logic [31:0] rsp_data;

    always_comb begin
        rsp_data = 32'd0;
        if (vld_p1 && !we_p1 && !err_p1)
            rsp_data = fmt_load(mem_rd_data, size_p1, uns_p1, off_p1);
    end

    assign p0_rsp_valid = vld_p1 & ~id_p1;
    assign p1_rsp_valid = vld_p1 &  id_p1;
    assign p0_rsp_err   = p0_rsp_valid & err_p1;
    assign p1_rsp_err   = p1_rsp_valid & err_p1;
    assign p0_rsp_rdata = p0_rsp_valid ? rsp_data : 32'd0;
    assign p1_rsp_rdata = p1_rsp_valid ? rsp_data : 32'd0;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter with a 256-word behavioural memory (1-cycle read latency).
module tb_rv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req_valid, p0_req_ready, p0_req_we, p0_req_unsigned;
    logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
    logic [1:0]  p0_req_size;
    logic        p0_rsp_valid, p0_rsp_err;
    logic        p1_req_valid, p1_req_ready, p1_req_we, p1_req_unsigned;
    logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
    logic [1:0]  p1_req_size;
    logic        p1_rsp_valid, p1_rsp_err;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic        mem_wr_en;
    logic [3:0]  mem_byte_en;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:255];

    rv_mem_arbiter #(.MEM_SIZE_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_size(p0_req_size), .p0_req_unsigned(p0_req_unsigned),
        .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_size(p1_req_size), .p1_req_unsigned(p1_req_unsigned),
        .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .p1_rsp_err(p1_rsp_err),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_byte_en(mem_byte_en), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem_rd_data = 32'd0;
    end

    always @(posedge clk) begin
        if (mem_wr_en && mem_addr < 32'd256)
            for (int k = 0; k < 4; k++)
                if (mem_byte_en[k]) mem[mem_addr[7:0]][8*k +: 8] <= mem_wr_data[8*k +: 8];
        mem_rd_data <= (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input int p, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd);
        if (p == 0) begin
            p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = addr;
            p0_req_size = size; p0_req_unsigned = uns; p0_req_wdata = wd;
        end else begin
            p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = addr;
            p1_req_size = size; p1_req_unsigned = uns; p1_req_wdata = wd;
        end
    endtask

    task automatic idle();
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        p0_req_we = 0; p0_req_addr = 0; p0_req_size = 0; p0_req_unsigned = 0; p0_req_wdata = 0;
        p1_req_we = 0; p1_req_addr = 0; p1_req_size = 0; p1_req_unsigned = 0; p1_req_wdata = 0;

        // 1: reset with both requesting
        req(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
        req(1, 1'b1, 32'h14, 2'b10, 1'b0, 32'h1234);
        #3;
        chk("rst_p0_rsp_valid", p0_rsp_valid, 0);
        chk("rst_p1_rsp_valid", p1_rsp_valid, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_byte_en", mem_byte_en, 0);
        tick();
        chk("rst_p0_rsp_valid_edge", p0_rsp_valid, 0);
        chk("rst_p1_rsp_rdata_edge", p1_rsp_rdata, 0);
        idle();
        rst_n = 1'b1;
        tick();

        // 2: SW then back-to-back LW of the same word
        req(1, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        #1;
        chk("sw_ready", p1_req_ready, 1);
        chk("sw_addr", mem_addr, 4);
        chk("sw_be", mem_byte_en, 4'b1111);
        chk("sw_wr_en", mem_wr_en, 1);
        chk("sw_wdata", mem_wr_data, 32'hDEADBEEF);
        tick();
        idle();
        chk("sw_rsp_valid", p1_rsp_valid, 1);
        chk("sw_rsp_err", p1_rsp_err, 0);
        chk("sw_rsp_rdata", p1_rsp_rdata, 0);
        chk("sw_p0_quiet", p0_rsp_valid, 0);
        req(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
        #1;
        chk("lw_ready", p0_req_ready, 1);
        chk("lw_wr_en", mem_wr_en, 0);
        tick();
        idle();
        chk("lw_rsp_valid", p0_rsp_valid, 1);
        chk("lw_rdata", p0_rsp_rdata, 32'hDEADBEEF);

        // 3: byte store into top lane, then signed/unsigned sub-word loads
        req(1, 1'b1, 32'h13, 2'b00, 1'b0, 32'h80);
        #1;
        chk("sb_be", mem_byte_en, 4'b1000);
        chk("sb_wdata", mem_wr_data, 32'h80000000);
        tick();
        idle();
        req(1, 1'b0, 32'h13, 2'b00, 1'b0, 32'd0);
        tick();
        chk("lb_rdata", p1_rsp_rdata, 32'hFFFFFF80);
        req(1, 1'b0, 32'h13, 2'b00, 1'b1, 32'd0);
        tick();
        chk("lbu_rdata", p1_rsp_rdata, 32'h00000080);
        req(1, 1'b0, 32'h12, 2'b01, 1'b0, 32'd0);
        tick();
        chk("lh_hi_rdata", p1_rsp_rdata, 32'hFFFF80AD);
        req(1, 1'b0, 32'h10, 2'b01, 1'b1, 32'd0);
        tick();
        chk("lhu_lo_rdata", p1_rsp_rdata, 32'h0000BEEF);
        idle();

        // 4: both requesting continuously from reset alternate p0,p1,p0,p1
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
        req(1, 1'b0, 32'h14, 2'b10, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_p0_ready_%0d", i), p0_req_ready, (i % 2 == 0));
            chk($sformatf("rr_p1_ready_%0d", i), p1_req_ready, (i % 2 == 1));
            tick();
            chk($sformatf("rr_p0_rsp_%0d", i), p0_rsp_valid, (i % 2 == 0));
            chk($sformatf("rr_p1_rsp_%0d", i), p1_rsp_valid, (i % 2 == 1));
            if (i % 2 == 0) chk($sformatf("rr_p0_rdata_%0d", i), p0_rsp_rdata, 32'h80ADBEEF);
        end
        idle();

        // 5: error cases are accepted but never touch memory
        req(0, 1'b0, 32'h3, 2'b01, 1'b0, 32'd0);
        #1;
        chk("mis_ready", p0_req_ready, 1);
        chk("mis_wr_en", mem_wr_en, 0);
        chk("mis_be", mem_byte_en, 0);
        tick();
        chk("mis_err", p0_rsp_err, 1);
        chk("mis_rdata", p0_rsp_rdata, 0);
        req(0, 1'b0, 32'h400, 2'b10, 1'b0, 32'd0);
        tick();
        chk("oor_err", p0_rsp_err, 1);
        req(0, 1'b0, 32'h10, 2'b11, 1'b0, 32'd0);
        tick();
        chk("ill_err", p0_rsp_err, 1);
        chk("ill_rdata", p0_rsp_rdata, 0);
        req(0, 1'b1, 32'h402, 2'b01, 1'b0, 32'hFFFF);
        #1;
        chk("oor_sw_wr_en", mem_wr_en, 0);
        tick();
        req(0, 1'b0, 32'h3FC, 2'b10, 1'b0, 32'd0);
        #1;
        chk("last_word_be", mem_byte_en, 4'b1111);
        tick();
        chk("last_word_err", p0_rsp_err, 0);
        idle();

        // 6: reset kills a pending response and re-favours p0
        req(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
        tick();
        idle();
        chk("pre_rst_p0_rsp", p0_rsp_valid, 1);
        req(1, 1'b0, 32'h14, 2'b10, 1'b0, 32'd0);
        #1;
        chk("pre_rst_p1_ready", p1_req_ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("in_rst_p1_ready", p1_req_ready, 0);
        tick();
        chk("drop_p1_rsp", p1_rsp_valid, 0);
        chk("drop_p0_rsp", p0_rsp_valid, 0);
        idle();
        rst_n = 1'b1;
        tick();
        chk("post_rst_p1_rsp", p1_rsp_valid, 0);
        req(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0);
        req(1, 1'b0, 32'h14, 2'b10, 1'b0, 32'd0);
        #1;
        chk("post_rst_p0_first", p0_req_ready, 1);
        chk("post_rst_p1_wait", p1_req_ready, 0);
        tick();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
